// File: rtl/seq_divider_param.sv
// ---------------------------------------------------------------------------
// seq_divider_param
//
// Sequential restoring integer divider with WIDTH-generic operands. It
// supports signed and unsigned modes. A request is accepted on a clock edge
// where start=1 and busy=0. The divider then runs one restoring step per
// cycle for WIDTH cycles. One more cycle applies the sign correction, and
// the results appear together with a one-cycle done pulse. The total
// latency from the accepting edge to done is WIDTH+2 cycles.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active low (0 = reset)
//   start        operation request; ignored while busy
//   signed_mode  1 = two's-complement divide, 0 = unsigned (latched with start)
//   dividend     WIDTH-bit dividend (latched with start)
//   divisor      WIDTH-bit divisor (latched with start)
//   busy         operation in progress
//   done         one-cycle pulse, results valid
//   quotient     result quotient, held until the next done
//   remainder    result remainder, held until the next done
//   div_by_zero  divisor was zero for the completed operation
//   overflow     signed MIN / -1 for the completed operation
// ---------------------------------------------------------------------------
module seq_divider_param #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] a_reg;        // dividend magnitude, shifts into quotient
    logic [WIDTH-1:0] b_mag_reg;    // divisor magnitude
    logic [WIDTH-1:0] p_reg;        // partial remainder (always < |B|)
    logic [WIDTH-1:0] dividend_reg; // original dividend, needed for divide-by-zero
    logic             q_neg_reg;
    logic             r_neg_reg;
    logic             dz_pend_reg;
    logic             ovf_pend_reg;

    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             done_reg;
    logic             div_by_zero_reg;
    logic             overflow_reg;

    // Operand magnitudes at the request. Negating MIN gives the same bit
    // pattern, and that pattern read as unsigned is exactly 2^(WIDTH-1).
    logic             a_neg_in;
    logic             b_neg_in;
    logic [WIDTH-1:0] a_mag_in;
    logic [WIDTH-1:0] b_mag_in;

    // One restoring step
    logic [WIDTH:0]   p_shift;
    logic             p_ge;
    logic [WIDTH-1:0] p_diff;

    // Sign-corrected results
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign a_neg_in = signed_mode & dividend[WIDTH-1];
    assign b_neg_in = signed_mode & divisor[WIDTH-1];
    assign a_mag_in = a_neg_in ? -dividend : dividend;
    assign b_mag_in = b_neg_in ? -divisor : divisor;

    assign p_shift = {p_reg, a_reg[WIDTH-1]};
    assign p_ge    = p_shift >= {1'b0, b_mag_reg};
    // The true difference is always below 2^WIDTH, so the low bits are enough.
    assign p_diff  = p_shift[WIDTH-1:0] - b_mag_reg;

    assign q_fix = q_neg_reg ? -a_reg : a_reg;
    assign r_fix = r_neg_reg ? -p_reg : p_reg;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                    state_next = S_FIX;
                end
            end
            S_FIX: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg         <= '0;
            a_reg           <= '0;
            b_mag_reg       <= '0;
            p_reg           <= '0;
            dividend_reg    <= '0;
            q_neg_reg       <= 1'b0;
            r_neg_reg       <= 1'b0;
            dz_pend_reg     <= 1'b0;
            ovf_pend_reg    <= 1'b0;
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            done_reg        <= 1'b0;
            div_by_zero_reg <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        cnt_reg      <= '0;
                        a_reg        <= a_mag_in;
                        b_mag_reg    <= b_mag_in;
                        p_reg        <= '0;
                        dividend_reg <= dividend;
                        q_neg_reg    <= a_neg_in ^ b_neg_in;
                        r_neg_reg    <= a_neg_in;
                        dz_pend_reg  <= (divisor == '0);
                        ovf_pend_reg <= signed_mode && (dividend == MIN_VAL) && (divisor == '1);
                    end
                end
                S_CALC: begin
                    p_reg   <= p_ge ? p_diff : p_shift[WIDTH-1:0];
                    a_reg   <= {a_reg[WIDTH-2:0], p_ge};
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
                S_FIX: begin
                    // With a zero divisor the result is all ones and the
                    // original dividend, independent of sign handling. MIN/-1
                    // already wraps to MIN with remainder 0 in the normal path.
                    if (dz_pend_reg) begin
                        quotient_reg  <= '1;
                        remainder_reg <= dividend_reg;
                    end else begin
                        quotient_reg  <= q_fix;
                        remainder_reg <= r_fix;
                    end
                    div_by_zero_reg <= dz_pend_reg;
                    overflow_reg    <= ovf_pend_reg;
                    done_reg        <= 1'b1;
                end
                default: begin
                    cnt_reg <= '0;
                end
            endcase
        end
    end

    assign busy        = (state_reg != S_IDLE);
    assign done        = done_reg;
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = div_by_zero_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_seq_divider_param.sv
// ---------------------------------------------------------------------------
// tb_seq_divider_param
//
// Bench for seq_divider_param using a 32-bit and an 8-bit instance. Issued
// operations push reference results to per-instance queues. Monitors pop
// the queues on done and compare the values, the flags and the exact
// completion cycle.
// ---------------------------------------------------------------------------
module tb_seq_divider_param;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    // 32-bit instance
    logic        start32 = 1'b0;
    logic        sm32 = 1'b0;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic        busy32, done32, dz32, ov32;
    logic [31:0] q32, r32;

    // 8-bit instance
    logic        start8 = 1'b0;
    logic        sm8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8, done8, dz8, ov8;
    logic [7:0]  q8, r8;

    exp_t sb32[$];
    exp_t sb8[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_divider_param #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .signed_mode(sm32),
        .dividend(a32), .divisor(b32), .busy(busy32), .done(done32),
        .quotient(q32), .remainder(r32), .div_by_zero(dz32), .overflow(ov32)
    );

    seq_divider_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .dividend(a8), .divisor(b8), .busy(busy8), .done(done8),
        .quotient(q8), .remainder(r8), .div_by_zero(dz8), .overflow(ov8)
    );

    // Reference model: signed arithmetic on 64-bit values, which truncates
    // toward zero with the remainder taking the dividend's sign.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input bit sm);
        exp_t   e;
        longint sa, sb, mask;
        mask = (longint'(1) << w) - 1;
        sa = longint'(a);
        sb = longint'(b);
        if (sm && a[w-1]) sa = sa - (longint'(1) << w);
        if (sm && b[w-1]) sb = sb - (longint'(1) << w);
        e.dz  = 1'b0;
        e.ov  = 1'b0;
        e.due = 0;
        if (sb == 0) begin
            e.q  = 32'(mask);
            e.r  = a;
            e.dz = 1'b1;
        end else if (sm && sa == -(longint'(1) << (w - 1)) && sb == -1) begin
            e.q  = 32'(longint'(1) << (w - 1));
            e.r  = '0;
            e.ov = 1'b1;
        end else begin
            e.q = 32'((sa / sb) & mask);
            e.r = 32'((sa % sb) & mask);
        end
        return e;
    endfunction

    // Scoreboard monitor, 32-bit instance
    always @(negedge clk) begin : mon32
        exp_t e;
        if (done32) begin
            if (sb32.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_done32 cyc=%0d q=%h r=%h", cyc, q32, r32);
            end else begin
                e = sb32.pop_front();
                n_cmp++;
                if (cyc !== e.due) begin
                    n_err++;
                    $display("FAIL latency32 done_cycle=%0d expected=%0d", cyc, e.due);
                end
                n_cmp++;
                if ({q32, r32} !== {e.q, e.r}) begin
                    n_err++;
                    $display("FAIL result32 q=%h r=%h expected q=%h r=%h", q32, r32, e.q, e.r);
                end
                n_cmp++;
                if ({dz32, ov32} !== {e.dz, e.ov}) begin
                    n_err++;
                    $display("FAIL flags32 dz=%b ov=%b expected dz=%b ov=%b", dz32, ov32, e.dz, e.ov);
                end
                $display("op32 done cyc=%0d q=%h r=%h dz=%b ov=%b", cyc, q32, r32, dz32, ov32);
            end
        end else if (sb32.size() > 0 && sb32[0].due < cyc) begin
            e = sb32.pop_front();
            n_cmp++; n_err++;
            $display("FAIL missing_done32 cyc=%0d expected_at=%0d", cyc, e.due);
        end
    end

    // Scoreboard monitor, 8-bit instance
    always @(negedge clk) begin : mon8
        exp_t e;
        if (done8) begin
            if (sb8.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_done8 cyc=%0d q=%h r=%h", cyc, q8, r8);
            end else begin
                e = sb8.pop_front();
                n_cmp++;
                if (cyc !== e.due) begin
                    n_err++;
                    $display("FAIL latency8 done_cycle=%0d expected=%0d", cyc, e.due);
                end
                n_cmp++;
                if ({q8, r8} !== {e.q[7:0], e.r[7:0]}) begin
                    n_err++;
                    $display("FAIL result8 q=%h r=%h expected q=%h r=%h", q8, r8, e.q[7:0], e.r[7:0]);
                end
                n_cmp++;
                if ({dz8, ov8} !== {e.dz, e.ov}) begin
                    n_err++;
                    $display("FAIL flags8 dz=%b ov=%b expected dz=%b ov=%b", dz8, ov8, e.dz, e.ov);
                end
                $display("op8 done cyc=%0d q=%h r=%h dz=%b ov=%b", cyc, q8, r8, dz8, ov8);
            end
        end else if (sb8.size() > 0 && sb8[0].due < cyc) begin
            e = sb8.pop_front();
            n_cmp++; n_err++;
            $display("FAIL missing_done8 cyc=%0d expected_at=%0d", cyc, e.due);
        end
    end

    // Drive one request. The caller must be at a falling edge with the
    // target instance idle. The task returns at the falling edge of cycle 1.
    task automatic issue(input bit use8, input logic [31:0] a, input logic [31:0] b, input bit sm);
        exp_t e;
        int   w;
        w = use8 ? 8 : 32;
        e = model(w, a, b, sm);
        e.due = cyc + w + 2;
        if (use8) begin
            start8 = 1'b1; sm8 = sm; a8 = a[7:0]; b8 = b[7:0];
            sb8.push_back(e);
        end else begin
            start32 = 1'b1; sm32 = sm; a32 = a; b32 = b;
            sb32.push_back(e);
        end
        @(negedge clk);
        start8  = 1'b0;
        start32 = 1'b0;
    endtask

    task automatic wait_idle(input bit use8);
        int pending;
        pending = use8 ? sb8.size() : sb32.size();
        for (int i = 0; i < 60 && pending != 0; i++) begin
            @(negedge clk);
            #1;
            pending = use8 ? sb8.size() : sb32.size();
        end
        @(negedge clk);
        n_cmp++;
        if (pending !== 0) begin
            n_err++;
            $display("FAIL wait_idle%0d pending=%0d required=0", use8 ? 8 : 32, pending);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy32, done32, q32, r32, dz32, ov32} !== '0) begin
            n_err++;
            $display("FAIL reset32 busy=%b done=%b q=%h r=%h required all zero", busy32, done32, q32, r32);
        end
        n_cmp++;
        if ({busy8, done8, q8, r8, dz8, ov8} !== '0) begin
            n_err++;
            $display("FAIL reset8 busy=%b done=%b q=%h r=%h required all zero", busy8, done8, q8, r8);
        end
        $display("reset checked cyc=%0d", cyc);
    endtask

    // 100/7: busy in cycles 1..33, done only in cycle 34
    task automatic test_timing();
        int busy_cnt, done_k, bad;
        busy_cnt = 0; done_k = -1; bad = 0;
        issue(1'b0, 32'd100, 32'd7, 1'b0);
        for (int k = 1; k <= 36; k++) begin
            if (busy32) busy_cnt++;
            if (done32) begin
                if (done_k < 0) done_k = k;
                if (busy32) bad++;
            end
            if (k <= 33 && !busy32) bad++;
            @(negedge clk);
        end
        n_cmp++;
        if (busy_cnt !== 33 || bad !== 0) begin
            n_err++;
            $display("FAIL busy_window busy_cycles=%0d bad=%0d required 33/0", busy_cnt, bad);
        end
        n_cmp++;
        if (done_k !== 34) begin
            n_err++;
            $display("FAIL done_cycle got=%0d required=34", done_k);
        end
        $display("timing 100/7 busy_cycles=%0d done_cycle=%0d", busy_cnt, done_k);
        wait_idle(1'b0);
    endtask

    task automatic test_signed();
        issue(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b1);              // -7 / 2
        wait_idle(1'b0);
        issue(1'b0, 32'd7, 32'hFFFF_FFFE, 1'b1);              // 7 / -2
        wait_idle(1'b0);
        issue(1'b0, 32'h8000_0000, 32'd3, 1'b1);              // MIN / 3
        wait_idle(1'b0);
        issue(1'b0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1);      // -100 / -7
        wait_idle(1'b0);
        issue(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0);              // same bits unsigned
        wait_idle(1'b0);
    endtask

    task automatic test_div_by_zero();
        issue(1'b0, 32'h0000_1234, 32'd0, 1'b0);
        wait_idle(1'b0);
        issue(1'b0, 32'h8765_4321, 32'd0, 1'b1);
        wait_idle(1'b0);
        issue(1'b1, 32'h85, 32'h00, 1'b1);
        wait_idle(1'b1);
    endtask

    task automatic test_overflow();
        issue(1'b1, 32'h80, 32'hFF, 1'b1);                    // -128 / -1
        wait_idle(1'b1);
        issue(1'b1, 32'hFF, 32'h01, 1'b0);
        wait_idle(1'b1);
        issue(1'b1, 32'h80, 32'hFF, 1'b0);                    // unsigned: no overflow
        wait_idle(1'b1);
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_idle(1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            issue(1'b1, $urandom_range(0, 255), (i % 6 == 0) ? 32'd1 : $urandom_range(0, 255), i[0]);
            wait_idle(1'b1);
        end
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, $urandom, (i == 2) ? 32'hFFFF_FFFF : ($urandom >> (i * 4)), i[0]);
            wait_idle(1'b0);
        end
    endtask

    // New operands and start mid-op are ignored; a start in the done cycle is accepted
    task automatic test_back_to_back();
        int found;
        found = 0;
        issue(1'b0, 32'd1000, 32'd3, 1'b0);
        repeat (3) @(negedge clk);
        start32 = 1'b1; sm32 = 1'b1; a32 = 32'd55; b32 = 32'd5;
        @(negedge clk);
        a32 = 32'd77; b32 = 32'd0;
        @(negedge clk);
        start32 = 1'b0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge clk);
            if (done32) found = 1;
        end
        n_cmp++;
        if (found !== 1) begin
            n_err++;
            $display("FAIL b2b_first_done found=%0d required=1", found);
        end
        issue(1'b0, 32'hFFFF_FFF0, 32'h10, 1'b1);            // -16 / 16 started in the done cycle
        n_cmp++;
        if ({busy32, done32} !== 2'b10) begin
            n_err++;
            $display("FAIL b2b_accept busy=%b done=%b required busy=1 done=0", busy32, done32);
        end
        $display("back_to_back second op accepted cyc=%0d", cyc);
        wait_idle(1'b0);
    endtask

    // Reset in cycle 10 aborts the operation and clears all outputs
    task automatic test_abort();
        issue(1'b0, 32'hDEAD_BEEF, 32'h11, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy32, done32, q32, r32, dz32, ov32} !== '0) begin
            n_err++;
            $display("FAIL abort_clear busy=%b done=%b q=%h r=%h required all zero", busy32, done32, q32, r32);
        end
        n_cmp++;
        if ({q8, r8} !== '0) begin
            n_err++;
            $display("FAIL abort_clear8 q=%h r=%h required 0", q8, r8);
        end
        sb32.delete();
        rst = 1'b1;
        repeat (40) @(negedge clk);
        $display("abort checked cyc=%0d", cyc);
        issue(1'b0, 32'd123456, 32'd789, 1'b0);
        wait_idle(1'b0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        test_reset();
        test_timing();
        test_signed();
        test_div_by_zero();
        test_overflow();
        test_back_to_back();
        test_abort();
        test_random();
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
